// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Takes configuration words from a valid/ready stream and shifts them
//   MSB-first into the head of the ccff configuration chain. It stops after
//   exactly CHAIN_LEN bits, and any unused low bits of the last word are
//   discarded.
//
// Ports
//   prog_clk, pReset  programming clock and synchronous active-high reset
//   start, abort      begin a load (IDLE/DONE only) / abandon the load
//   bs_data/valid/ready  bitstream word stream
//   ccff_head         serial bit into the chain head
//   ccff_shift_en     chain advances on the edge where this is 1
//   busy, done        LOAD/SHIFT in progress / CHAIN_LEN bits delivered
//   bit_count         bits shifted since the last start
//   crc_expected, crc_error  CRC-16-CCITT check of the delivered bits
//
// Optional feature: define CCFF_LOADER_CRC_EN to build the CRC checker.
// Without it, crc_expected is ignored and crc_error is tied to 0.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  input  logic [15:0]       crc_expected,
  output logic              crc_error
);

  localparam int REM_W = $clog2(WORD_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [31:0]       bits_left;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    rem_d       = rem_q;
    bits_left   = 32'(CHAIN_LEN) - 32'(bit_count_q);

    if (abort) begin
      state_d     = ST_IDLE;
      shreg_d     = '0;
      bit_count_d = '0;
      rem_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d     = ST_LOAD;
            bit_count_d = '0;
          end
        end
        ST_LOAD: begin
          if (bs_valid) begin
            shreg_d = bs_data;
            // If the last word is only partly used, shift only the bits the chain still needs.
            rem_d   = (bits_left < 32'(WORD_W)) ? REM_W'(bits_left) : REM_W'(WORD_W);
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_d     = shreg_q << 1;
          bit_count_d = bit_count_q + 1'b1;
          rem_d       = rem_q - 1'b1;
          if (rem_q == REM_W'(1)) begin
            state_d = (bit_count_d == LAST_CNT) ? ST_DONE : ST_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_count_q <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_count_q <= bit_count_d;
      rem_q       <= rem_d;
    end
  end

  assign bs_ready      = (state_q == ST_LOAD);
  assign ccff_shift_en = (state_q == ST_SHIFT);
  assign ccff_head     = ccff_shift_en & shreg_q[WORD_W-1];
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign done          = (state_q == ST_DONE);
  assign bit_count     = bit_count_q;

`ifdef CCFF_LOADER_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;
  logic        crc_error_q, crc_error_d;
  logic        crc_fb;

  always_comb begin
    crc_d       = crc_q;
    crc_error_d = crc_error_q;
    crc_fb      = crc_q[15] ^ shreg_q[WORD_W-1];
    crc_next    = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    if (abort) begin
      crc_d       = 16'hFFFF;
      crc_error_d = 1'b0;
    end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      crc_d       = 16'hFFFF;
      crc_error_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      crc_d = crc_next;
      // Compare using the CRC that already includes the final bit.
      if (state_d == ST_DONE) begin
        crc_error_d = (crc_next != crc_expected);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      crc_q       <= 16'hFFFF;
      crc_error_q <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      crc_error_q <= crc_error_d;
    end
  end

  assign crc_error = crc_error_q;
`else
  logic unused_crc_expected;
  assign unused_crc_expected = ^crc_expected;
  assign crc_error           = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Testbench for ccff_bitstream_loader.
// The stimulus tasks push the expected chain bits and the expected completion
// record (latency and crc_error) into queues. A negedge monitor pops from those
// queues when the DUT shifts a bit or raises done.
module tb_ccff_bitstream_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              prog_clk = 1'b0;
  logic              pReset, start, abort, bs_valid;
  logic [WORD_W-1:0] bs_data;
  logic              bs_ready, ccff_head, ccff_shift_en, busy, done, crc_error;
  logic [CNT_W-1:0]  bit_count;
  logic [15:0]       crc_expected;

  ccff_bitstream_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .abort        (abort),
    .bs_data      (bs_data),
    .bs_valid     (bs_valid),
    .bs_ready     (bs_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .busy         (busy),
    .done         (done),
    .bit_count    (bit_count),
    .crc_expected (crc_expected),
    .crc_error    (crc_error)
  );

  typedef struct {
    int lat;
    bit crc_err;
  } done_exp_t;

  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;
  int        start_cyc = 0;
  bit        exp_bits[$];
  done_exp_t exp_done[$];
  logic [WORD_W-1:0] words[NW];
  int        stalls[NW];
  logic      done_prev = 1'b0;

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input bit s[CHAIN_LEN]);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      if (c[15] ^ s[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  // Monitor: compares the chain bits and the completion record.
  always @(negedge prog_clk) begin
    if (ccff_shift_en === 1'b1) begin
      if (exp_bits.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_shift: actual=shift required=no_shift (cyc %0d)", cyc);
      end else begin
        bit b;
        b = exp_bits.pop_front();
        chk("ccff_head", 32'(ccff_head), 32'(b));
      end
    end else begin
      chk("head_idle", 32'(ccff_head), 0);
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=1 required=0 (cyc %0d)", cyc);
      end else begin
        done_exp_t e;
        e = exp_done.pop_front();
        chk("done_latency", cyc - start_cyc, e.lat);
        chk("done_bit_count", 32'(bit_count), CHAIN_LEN);
        chk("crc_error", 32'(crc_error), 32'(e.crc_err));
      end
    end
    done_prev <= done;
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_bs_ready"}, 32'(bs_ready), 0);
    chk({tag, "_head"}, 32'(ccff_head), 0);
    chk({tag, "_shift_en"}, 32'(ccff_shift_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_bit_count"}, 32'(bit_count), 0);
    chk({tag, "_crc_error"}, 32'(crc_error), 0);
  endtask

  // Builds the expected stream from words[] and stalls[], then issues start.
  task automatic launch(input bit full, input bit inject);
    bit          stream[CHAIN_LEN];
    logic [15:0] c;
    int          lat;
    bit          err;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      stream[i] = words[i / WORD_W][WORD_W - 1 - (i % WORD_W)];
      exp_bits.push_back(stream[i]);
    end
    c = crc_model(stream);
    crc_expected = c ^ {15'd0, inject};
`ifdef CCFF_LOADER_CRC_EN
    err = inject;
`else
    err = 1'b0;
`endif
    lat = 1 + NW + CHAIN_LEN;
    for (int k = 0; k < NW; k++) lat += stalls[k];
    if (full) exp_done.push_back('{lat: lat, crc_err: err});
    @(negedge prog_clk);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge prog_clk);
    #1 start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(bs_ready), 1);
    chk("start_done_clr", 32'(done), 0);
    chk("start_count_clr", 32'(bit_count), 0);
    chk("start_crc_clr", 32'(crc_error), 0);
  endtask

  task automatic send_word(input int k);
    int t;
    t = 0;
    @(negedge prog_clk);
    while (bs_ready !== 1'b1 && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: actual=0 required=1 (word %0d)", k);
      return;
    end
    bs_data = words[k];
    repeat (stalls[k]) @(negedge prog_clk);
    bs_valid = 1'b1;
    @(posedge prog_clk);
    #1 bs_valid = 1'b0;
    bs_data = WORD_W'($urandom);
  endtask

  task automatic full_load(input bit mid_start, input bit inject);
    int t;
    launch(1'b1, inject);
    for (int k = 0; k < NW; k++) begin
      send_word(k);
      if (mid_start && k == 0) begin
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1 start = 1'b0;
      end
    end
    t = 0;
    @(negedge prog_clk);
    while (done !== 1'b1 && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual=0 required=1");
    end
    for (int r = 0; r < 3; r++) begin
      @(negedge prog_clk);
      bs_valid = 1'b1;
      bs_data  = WORD_W'($urandom);
      chk("done_no_ready", 32'(bs_ready), 0);
      chk("done_hold", 32'(done), 1);
      chk("done_count_hold", 32'(bit_count), CHAIN_LEN);
    end
    bs_valid = 1'b0;
    chk("stream_drained", exp_bits.size(), 0);
  endtask

  task automatic random_words(input int max_stall);
    for (int k = 0; k < NW; k++) begin
      words[k]  = WORD_W'($urandom);
      stalls[k] = int'($urandom_range(max_stall, 0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t;
    pReset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bs_valid = 1'b0;
    bs_data = '0;
    crc_expected = '0;
    repeat (3) @(negedge prog_clk);
    check_all_zero("reset");
    pReset = 1'b0;

    // Directed: A5 3C F0, no stalls, CRC consistent.
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
    stalls[0] = 0; stalls[1] = 0; stalls[2] = 0;
    full_load(1'b0, 1'b0);

    // Directed: 5-cycle stall before the second word.
    stalls[1] = 5;
    full_load(1'b0, 1'b0);

    // CRC mismatch; the following load checks that start clears it.
    stalls[1] = 0;
    full_load(1'b0, 1'b1);

    // Abort after 10 shifted bits.
    random_words(0);
    launch(1'b0, 1'b0);
    send_word(0);
    send_word(1);
    t = 0;
    @(negedge prog_clk);
    while (bit_count !== CNT_W'(10) && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    chk("abort_reach10", 32'(bit_count), 10);
    abort = 1'b1;
    @(posedge prog_clk);
    #1 abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_count", 32'(bit_count), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_shift_en", 32'(ccff_shift_en), 0);
    chk("abort_ready", 32'(bs_ready), 0);
    chk("abort_bits_left", exp_bits.size(), CHAIN_LEN - 11);
    exp_bits.delete();
    repeat (5) @(negedge prog_clk);
    random_words(0);
    full_load(1'b0, 1'b0);

    // pReset in the middle of SHIFT.
    random_words(0);
    launch(1'b0, 1'b0);
    send_word(0);
    repeat (3) @(negedge prog_clk);
    pReset = 1'b1;
    @(posedge prog_clk);
    #1 check_all_zero("midreset");
    pReset = 1'b0;
    exp_bits.delete();
    repeat (3) @(negedge prog_clk);

    // Randomized loads with stalls, start pulses during SHIFT, and occasional CRC errors.
    for (int it = 0; it < 8; it++) begin
      random_words(3);
      full_load(it[0], (it == 5));
    end

    chk("done_queue_empty", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Upstream configuration stage for the configuration-chain flip-flop (ccff) path of the CLB/fle fabric tiles.
- Accepts bitstream words over a valid/ready stream and serializes them MSB-first onto the head of the chain.
- Drives a shift-enable so the downstream clock gate only advances the chain while a valid bit is present.
- Counts bits, stops exactly at the chain length, truncates the final partial word, and flags completion.

Parameters:
- WORD_W, 8: bitstream word width in bits.
- CHAIN_LEN, 20: total ccff bits in the driven chain; must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter.

Ports:
- prog_clk  in  1  programming clock.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- abort  in  1  synchronous abandon of the current load.
- bs_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- bs_valid  in  1  bs_data valid.
- bs_ready  out  1  loader can accept a word.
- ccff_head  out  1  serial configuration bit into the chain head.
- ccff_shift_en  out  1  chain advances on the prog_clk edge where this is 1.
- busy  out  1  high in LOAD or SHIFT.
- done  out  1  CHAIN_LEN bits delivered.
- bit_count  out  CNT_W  bits shifted since the last start.
- crc_expected  in  16  expected CRC; used only with the optional feature.
- crc_error  out  1  CRC mismatch; used only with the optional feature.

Behaviour:
- Clock and reset: one clock, prog_clk. pReset is synchronous and active-high.
- Reset state: on pReset, state=IDLE and the shift register and bit_count are 0. bs_ready, ccff_head, ccff_shift_en, busy, done and crc_error are all 0.
- Reset or abort mid-load: the chain holds its partial contents; no further shifts occur.
- Output timing: all outputs are decoded from registered state. There is no combinational path from inputs to outputs.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: start=1 → LOAD on the next cycle, and bit_count clears to 0.
- LOAD:
  - bs_ready=1.
  - bs_valid=1 → the word is captured into the shift register; remaining-in-word count = min(WORD_W, CHAIN_LEN - bit_count); next state is SHIFT.
  - bs_valid=0 → stay in LOAD with ccff_shift_en=0, so the chain holds (stall tolerance is unlimited).
- SHIFT, per cycle:
  - ccff_shift_en=1 and ccff_head = shreg[WORD_W-1].
  - shreg shifts left, filling with 0; bit_count increments; remaining-in-word count decrements.
- SHIFT exit, on the cycle the last bit of the word shifts:
  - If bit_count+1 == CHAIN_LEN → DONE.
  - Otherwise → LOAD.
  - bs_ready is 0 throughout SHIFT.
- Throughput: WORD_W+1 cycles per full word. A CHAIN_LEN-bit load takes ceil(CHAIN_LEN/WORD_W) LOAD cycles plus CHAIN_LEN SHIFT cycles when there are no stalls.
- Final partial word: only the upper (CHAIN_LEN mod WORD_W) bits are shifted; the low bits are discarded.
- DONE: done=1 and bit_count holds at CHAIN_LEN. bs_ready=0; words offered in DONE are not accepted. start=1 → LOAD with bit_count cleared and done cleared in the same transition.
- start outside IDLE/DONE: ignored.
- abort: takes effect in any state, next cycle → IDLE. It clears bit_count, done and busy, and takes priority over start and bs_valid in the same cycle.
- Outputs outside SHIFT: ccff_head=0 and ccff_shift_en=0.
- Counter rules: bit_count never exceeds CHAIN_LEN and never wraps.

Optional Feature:
- Macro: CCFF_LOADER_CRC_EN.
- With the macro defined:
  - A bit-serial CRC-16-CCITT runs over every bit driven on ccff_head while ccff_shift_en=1.
  - Polynomial 0x1021, initial value 0xFFFF, no reflection, no final XOR.
  - Update rule: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 0x1021 : 0).
  - The CRC reinitialises on start, abort and pReset.
  - On the transition into DONE, crc_error is registered as (crc_final != crc_expected); it holds until the next start, abort or pReset.
- Without the macro: no CRC logic is built, crc_expected is unused and crc_error is tied to 0.

Test Plan (all with WORD_W=8, CHAIN_LEN=20):
- Basic load, no stalls: start, then words 0xA5, 0x3C, 0xF0 with bs_valid held high → ccff_head sequence 10100101 00111100 1111 on 20 ccff_shift_en cycles; done=1 and bit_count=20 on cycle 23 after the start-cycle LOAD entry; the low nibble of 0xF0 is never shifted.
- Stall: bs_valid deasserted for 5 cycles in LOAD between words 1 and 2 → ccff_shift_en=0 for exactly those 5 cycles; the bit sequence is identical to the basic load; done is delayed by 5 cycles.
- Abort: abort after 10 shifted bits → IDLE next cycle; busy=0, bit_count=0, done=0; no further ccff_shift_en pulses. A following start re-loads all 20 bits correctly.
- Reset and done behaviour: pReset asserted mid-SHIFT → every output is 0 on the next cycle. start issued in SHIFT is ignored. In DONE, bs_valid=1 is never accepted (bs_ready=0).
- CRC match (CCFF_LOADER_CRC_EN): load the basic bitstream with crc_expected set to the bench-model CRC of those 20 bits → crc_error=0 in DONE.
- CRC mismatch (CCFF_LOADER_CRC_EN): crc_expected set to the model CRC XOR 0x0001 → crc_error=1 in DONE, cleared by the next start.
